cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's fixed 4-bit lookahead adder.
- Operand width, lookahead group size and pipeline depth are configurable.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides so it can sit directly in datapath streams.
- Each pipeline stage resolves one segment of the word using group generate/propagate logic. The carry between segments is registered.

---
 rtl/cla_addsub_pipe.sv | 136 +++++++++++++
 tb/tb_cla_addsub_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor, one word segment per stage, valid/ready on both sides
module cla_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             OVF,
  output logic             ZERO
);
  localparam int NS  = STAGES < 1 ? 1 : STAGES;
  localparam int GR  = GROUP < 1 ? 1 : GROUP;
  localparam int SEG = WIDTH / NS;

  if (STAGES < 1 || GROUP < 1 || WIDTH % NS != 0 || SEG % GR != 0) begin : g_bad
    $error("cla_addsub_pipe: WIDTH/STAGES must be a multiple of GROUP and STAGES >= 1");
  end

  // returns {carry out, carry into top bit, sum}; bit and group carries are flat G/P products
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] g, p;
    logic [SEG:0] cy;
    logic t, acc;
    g = x & y;
    p = x ^ y;
    cy = '0;
    cy[0] = ci;
    for (int n = 0; n < SEG; n += GR) begin
      for (int j = 1; j <= GR; j++) begin
        acc = cy[n];
        for (int i = 0; i < j; i++) acc &= p[n+i];
        for (int i = 0; i < j; i++) begin
          t = g[n+i];
          for (int m = i + 1; m < j; m++) t &= p[n+m];
          acc |= t;
        end
        cy[n+j] = acc;
      end
    end
    return {cy[SEG], cy[SEG-1], p ^ cy[SEG-1:0]};
  endfunction

  logic             advance;
  logic             iv, ic;
  logic [WIDTH-1:0] ia, ib;
  logic             v [NS];
  logic             c [NS];
  logic [WIDTH-1:0] a [NS];
  logic [WIDTH-1:0] b [NS];
  logic [WIDTH-1:0] s [NS];
  logic [WIDTH-1:0] ns [NS];
  logic [SEG+1:0]   r [NS];
  logic             cf, of, zf;

  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = v[NS-1];
  assign S         = s[NS-1];
  assign C_out     = cf;
  assign OVF       = of;
  assign ZERO      = zf;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iv <= 1'b0;
      ic <= 1'b0;
      ia <= '0;
      ib <= '0;
    end else if (advance) begin
      iv <= in_valid;
      if (in_valid) begin
        ia <= A;
        ib <= B ^ {WIDTH{SUB}};
        ic <= SUB | C_in;
      end
    end

  for (genvar k = 0; k < NS; k++) begin : st
    logic             pv, pc;
    logic [WIDTH-1:0] pa, pb;
    if (k == 0) begin : g_src
      assign pv = iv;
      assign pc = ic;
      assign pa = ia;
      assign pb = ib;
      assign ns[k] = WIDTH'(r[k][SEG-1:0]);
    end else begin : g_src
      assign pv = v[k-1];
      assign pc = c[k-1];
      assign pa = a[k-1];
      assign pb = b[k-1];
      assign ns[k] = s[k-1] | (WIDTH'(r[k][SEG-1:0]) << (k * SEG));
    end
    assign r[k] = seg_add(pa[k*SEG +: SEG], pb[k*SEG +: SEG], pc);
    // data fields only load with a valid beat so bubbles never disturb S or the flags
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v[k] <= 1'b0;
        c[k] <= 1'b0;
        a[k] <= '0;
        b[k] <= '0;
        s[k] <= '0;
      end else if (advance) begin
        v[k] <= pv;
        if (pv) begin
          c[k] <= r[k][SEG+1];
          a[k] <= pa;
          b[k] <= pb;
          s[k] <= ns[k];
        end
      end
    if (k == NS - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cf <= 1'b0;
          of <= 1'b0;
          zf <= 1'b0;
        end else if (advance && pv) begin
          cf <= r[k][SEG+1];
          of <= r[k][SEG+1] ^ r[k][SEG];
          zf <= ns[k] == '0;
        end
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: scoreboard bench with directed cases on the default build and random runs over STAGES/GROUP
module tb_cla_addsub_pipe;
  localparam int NR = 6;
  localparam int RS [NR] = '{1, 2, 4, 1, 2, 4};
  localparam int RG [NR] = '{2, 2, 2, 4, 4, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0, rdone = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference: plain integer add, overflow from operand/result signs
  function automatic logic [18:0] model(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs);
    logic [15:0] bo;
    logic [16:0] t;
    logic        o;
    bo = xs ? ~xb : xb;
    t = {1'b0, xa} + {1'b0, bo} + {16'd0, xs ? 1'b1 : xc};
    o = (xa[15] == bo[15]) && (t[15] != xa[15]);
    return {t[16], o, t[15:0] == 16'd0, t[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, s;
  logic [18:0] q [$];
  logic [18:0] me;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .C_in(cin), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready), .S(s),
    .C_out(cout), .OVF(ovf), .ZERO(zero));

  always @(negedge clk)
    if (!rst_n) q.delete();
    else if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("result", {cout, ovf, zero, s}, me);
      end
    end

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs);
    int n = 0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    sub = xs;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    #1 chk("reset_state", {out_valid, cout, ovf, zero, s}, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_reset", in_ready, 1);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 2);
    repeat (3) @(posedge clk);
    #1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    fork
      begin
        send(16'd1, 16'd1, 1'b0, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b0);
        send(16'd3, 16'd3, 1'b0, 1'b0);
      end
      begin
        int m = 0;
        while (!out_valid && m < 20) begin
          @(posedge clk);
          #1 m++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_S", s, 16'h0002);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("drain_valid", out_valid, 1);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    send(16'd10, 16'd20, 1'b0, 1'b0);
    send(16'd30, 16'd40, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk("async_reset", {out_valid, s}, 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_beat_after_reset", out_valid, 0);
    end
    @(posedge clk);
    #1 send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    chk("directed_drain", q.size(), 0);
    n = 0;
    while (rdone < NR && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("random_done", rdone, NR);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  for (genvar g = 0; g < NR; g++) begin : rnd
    logic        rr_n = 1'b0, iv = 1'b0, ordy = 1'b0, xc = 1'b0, xs = 1'b0;
    logic        ir, ov, co, of, zf;
    logic [15:0] xa = '0, xb = '0, so;
    logic [18:0] rq [$];
    logic [18:0] re;
    int          acc = 0;

    cla_addsub_pipe #(.WIDTH(16), .GROUP(RG[g]), .STAGES(RS[g])) u (
      .clk(clk), .rst_n(rr_n), .in_valid(iv), .in_ready(ir), .A(xa), .B(xb),
      .C_in(xc), .SUB(xs), .out_valid(ov), .out_ready(ordy), .S(so),
      .C_out(co), .OVF(of), .ZERO(zf));

    always @(negedge clk)
      if (!rr_n) rq.delete();
      else if (iv && ir) begin
        rq.push_back(model(xa, xb, xc, xs));
        acc++;
      end

    always @(negedge clk)
      if (rr_n && ov && ordy) begin
        chk("rand_sb_nonempty", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          re = rq.pop_front();
          chk("rand_result", {co, of, zf, so}, re);
        end
      end

    initial begin
      int n = 0;
      repeat (3) @(posedge clk);
      #1 rr_n = 1'b1;
      while (acc < 10000 && n < 50000) begin
        @(posedge clk);
        #1 n++;
        iv = ($urandom_range(3) != 0);
        xa = pick();
        xb = ($urandom_range(7) == 0) ? xa : pick();
        xc = 1'($urandom_range(1));
        xs = 1'($urandom_range(1));
        ordy = ($urandom_range(3) != 0);
      end
      iv = 1'b0;
      ordy = 1'b1;
      chk("rand_beats", acc, 10000);
      n = 0;
      while (rq.size() > 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      chk("rand_drain", rq.size(), 0);
      rdone++;
    end
  end
endmodule
